mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: the maximum number of ACCESS cycles without mem_ack before a bus error is declared.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: the MEM stage presents a load or store this cycle.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_op, input, 3: 000 word, 001 byte signed, 010 half signed, 011 byte unsigned, 100 half unsigned; 101-111 are illegal.
REQ-007 SHALL have port req_addr, input, 32: the byte address.
REQ-008 SHALL have port req_wdata, input, 32: store data, taken from bits [7:0], [15:0] or [31:0] according to size.
REQ-009 SHALL have port stall, output, 1: freezes the pipeline while an access is in flight.
REQ-010 SHALL have port rdata, output, 32: the extended load result.
REQ-011 SHALL have port rdata_valid, output, 1: a one-cycle completion pulse.
REQ-012 SHALL have port misalign, output, 1: flags an illegal address or op on the current request.
REQ-013 SHALL have port bus_err, output, 1: a one-cycle timeout flag.
REQ-014 SHALL have memory-side ports: mem_req out 1; mem_we out 1; mem_be out 4; mem_addr out 32; mem_wdata out 32; mem_ack in 1; mem_rdata in 32.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-016 SHALL, in IDLE with req_valid=1 and a legal request, register the request and go to ACCESS; stall=1 combinationally that same cycle.
REQ-017 SHALL treat a request as misaligned when: word with addr[1:0]!=0; half with addr[0]!=0; or op 101-111.
REQ-018 SHALL, for a misaligned request in IDLE, drive misalign=1 combinationally, keep stall=0, make no memory access and stay in IDLE.
REQ-019 SHALL, in ACCESS: hold mem_req=1 and all mem_* outputs stable until mem_ack=1; stall=1; mem_addr={addr[31:2],2'b00}.
REQ-020 SHALL, on mem_ack in ACCESS: capture the extended load data into rdata, go to DONE, and drive mem_req=0 from the next cycle.
REQ-021 SHALL count wait cycles in ACCESS; after MAX_WAIT cycles without ack, set mem_req=0, go to DONE with bus_err=1 and rdata=0.
REQ-022 SHALL, in DONE (one cycle): rdata_valid=1 and stall=0; ignore req_valid; return to IDLE.
REQ-023 SHALL hold rdata until the next completion and give rdata_valid=1 for stores too, with rdata=0.
REQ-024 SHALL drive byte enables for stores: sb be=4'b0001<<addr[1:0], wdata={4{b}}; sh be=addr[1]?4'b1100:4'b0011, wdata={2{h}}; sw be=4'b1111, wdata=req_wdata.
REQ-025 SHALL, for loads, drive mem_we=0 and be=4'b1111, and select the byte/half lane by addr[1:0], sign- or zero-extended per op.
REQ-026 SHALL ignore mem_ack outside ACCESS.
REQ-027 SHALL give a zero-wait memory (ack in the first ACCESS cycle) a completion latency of 2 cycles from acceptance.

Reset
REQ-028 SHALL, on reset, force state IDLE, wait counter 0, rdata 0, and all of rdata_valid, bus_err, mem_req, mem_we, mem_be, mem_addr and mem_wdata to 0.
REQ-029 SHALL, on reset mid-ACCESS, abandon the access, drop mem_req the next cycle and discard any later ack.

Structure
REQ-030 SHALL place the req_op encodings, the FSM state encoding and the MAX_WAIT default in a shared package mem_pkg.
REQ-031 SHALL implement lane selection and extension in one combinational sub-module, load_extend, instantiated once.

Verification
REQ-032 SHALL cover: lb at addr 0x1003, mem_rdata 0x80FF_1234, ack in the first ACCESS cycle -> rdata 0xFFFF_FF80, rdata_valid at acceptance+2, stall high for 2 cycles.
REQ-033 SHALL cover: lhu at addr 0x2002, mem_rdata 0xBEEF_0001 -> rdata 0x0000_BEEF.
REQ-034 SHALL cover: sb at addr 0x11, wdata 0x0000_00AB, ack after 3 cycles -> mem_be 4'b0010, mem_wdata 0xABAB_ABAB, mem_addr 0x10, all held stable until ack.
REQ-035 SHALL cover: lw at addr 0x6 -> misalign=1, stall=0, mem_req never asserted.
REQ-036 SHALL cover: no ack for 15 ACCESS cycles -> bus_err=1 with rdata_valid=1 and rdata=0, mem_req dropped, a later ack ignored.
REQ-037 SHALL cover: reset asserted in the second ACCESS cycle -> all outputs 0 the next cycle; an ack arriving afterwards produces no rdata_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access controller: request ops, FSM states,
// default timeout, and the request legality rule.
package mem_pkg;

   localparam int MAX_WAIT_DEF = 15;

   typedef enum logic [2:0] {
      OP_WORD   = 3'b000,
      OP_BYTE_S = 3'b001,
      OP_HALF_S = 3'b010,
      OP_BYTE_U = 3'b011,
      OP_HALF_U = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   // Unaligned word/half addresses and the unused op codes are both rejected.
   function automatic logic is_illegal(input logic [2:0] op, input logic [1:0] lo);
      logic bad;
      case (op_e'(op))
         OP_WORD:              bad = (lo != 2'b00);
         OP_HALF_S, OP_HALF_U: bad = lo[0];
         OP_BYTE_S, OP_BYTE_U: bad = 1'b0;
         default:              bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane out of a memory word and sign- or
// zero-extends it according to the load op.
module load_extend
   import mem_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] data,
   output logic [31:0] ext
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = data[{lane, 3'b000} +: 8];
      half_v = lane[1] ? data[31:16] : data[15:0];
      case (op_e'(op))
         OP_BYTE_S: ext = {{24{byte_v[7]}}, byte_v};
         OP_BYTE_U: ext = {24'h0, byte_v};
         OP_HALF_S: ext = {{16{half_v[15]}}, half_v};
         OP_HALF_U: ext = {16'h0, half_v};
         default:   ext = data;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: accepts one request, holds the memory bus
// until ack or timeout, then reports a one-cycle completion.
//
// state  | meaning
// IDLE   | waiting for a legal request; misaligned ones are flagged and dropped
// ACCESS | mem_req held with stable bus fields until ack or wait timeout
// DONE   | one-cycle completion: rdata_valid, optional bus_err
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   state_e        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [2:0]    op_q;
   logic [1:0]    lane_q;
   logic          timeout_q;
   logic          illegal;
   logic          accept;
   logic          ack_done;
   logic          timeout;
   logic [3:0]    be_nxt;
   logic [31:0]   wdata_nxt;
   logic [31:0]   load_val;

   assign illegal = is_illegal(req_op, req_addr[1:0]);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_done  = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid && !illegal) begin
               accept    = 1'b1;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               ack_done  = 1'b1;
               state_nxt = ST_DONE;
            end else if (wait_cnt == '0) begin
               timeout   = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      stall       = accept || (state == ST_ACCESS);
      misalign    = (state == ST_IDLE) && req_valid && illegal;
      rdata_valid = (state == ST_DONE);
      bus_err     = (state == ST_DONE) && timeout_q;
   end

   // Store lane steering; loads always read the full word.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = req_wdata;
      if (req_write) begin
         case (op_e'(req_op))
            OP_BYTE_S, OP_BYTE_U: begin
               be_nxt    = 4'b0001 << req_addr[1:0];
               wdata_nxt = {4{req_wdata[7:0]}};
            end
            OP_HALF_S, OP_HALF_U: begin
               be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   load_extend u_load_extend (
      .op   (op_q),
      .lane (lane_q),
      .data (mem_rdata),
      .ext  (load_val)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         op_q      <= '0;
         lane_q    <= '0;
         timeout_q <= 1'b0;
         rdata     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (accept) begin
            wait_cnt  <= CW'(MAX_WAIT - 1);
            op_q      <= req_op;
            lane_q    <= req_addr[1:0];
            timeout_q <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= req_write;
            mem_be    <= be_nxt;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= wdata_nxt;
         end
         if (ack_done) begin
            mem_req <= 1'b0;
            rdata   <= mem_we ? 32'h0 : load_val;
         end else if (timeout) begin
            mem_req   <= 1'b0;
            rdata     <= 32'h0;
            timeout_q <= 1'b1;
         end else if (state == ST_ACCESS) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end

endmodule
